tm_train_engine: RTL and testbench

- Training and inference front end for a 2-class Tsetlin Machine.
- Holds the Tsetlin automaton (TA) state for every clause of every class and evaluates the clauses for a presented feature vector.
- Emits the per-class positive/negative clause vectors and the predicted class to the downstream vote comparator.
- When training, applies Type I/II feedback to the TA states. This is the learning direction that complements the inference-only vote comparator.

---
 rtl/tm_pkg.sv | 22 ++
 rtl/tm_train_engine_if.sv | 35 +++
 rtl/tm_clause_update.sv | 33 +++
 rtl/tm_train_engine.sv | 177 +++++++++++++++++
 tb/tb_tm_train_engine.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// Shared constants and types for the Tsetlin Machine training engine.
// Holds default geometry (feature/clause counts, TA state width, literal
// count, vote width), the TA reset value, the feedback-type enum and the
// engine FSM state enum.
package tm_pkg;
    localparam int TM_N_FEAT   = 2;
    localparam int TM_N_CLAUSE = 2;
    localparam int TM_SW       = 4;
    localparam int TM_NL       = 2 * TM_N_FEAT;
    // signed vote range is -N_CLAUSE..N_CLAUSE
    localparam int TM_VW       = $clog2(TM_N_CLAUSE + 1) + 1;

    // Largest "excluded" state: just below the include boundary.
    function automatic int ta_rst_val(input int sw);
        return (1 << (sw - 1)) - 1;
    endfunction

    localparam logic [TM_SW-1:0] TM_TA_RST = TM_SW'(ta_rst_val(TM_SW));

    typedef enum logic [1:0] {FB_NONE, FB_TYPE1, FB_TYPE2} fb_t;
    typedef enum logic [1:0] {IDLE, EVAL, UPD, DONE} state_t;
endpackage

// File: rtl/tm_train_engine_if.sv
// Sample/result handshake bundle for tm_train_engine.
// master: sample producer / result consumer (drives in_valid, x, label,
//         train, rand_en, out_ready).
// slave : the engine (drives in_ready, out_valid, clause vectors, pred_class).
interface tm_train_engine_if
    import tm_pkg::*;
#(
    parameter int N_FEAT   = TM_N_FEAT,
    parameter int N_CLAUSE = TM_N_CLAUSE
);
    logic                in_valid;
    logic                in_ready;
    logic [N_FEAT-1:0]   x;
    logic                label;
    logic                train;
    logic                rand_en;
    logic                out_valid;
    logic                out_ready;
    logic [N_CLAUSE-1:0] pos_clause_1;
    logic [N_CLAUSE-1:0] neg_clause_1;
    logic [N_CLAUSE-1:0] pos_clause_2;
    logic [N_CLAUSE-1:0] neg_clause_2;
    logic [1:0]          pred_class;

    modport master (
        output in_valid, x, label, train, rand_en, out_ready,
        input  in_ready, out_valid, pos_clause_1, neg_clause_1,
               pos_clause_2, neg_clause_2, pred_class
    );
    modport slave (
        input  in_valid, x, label, train, rand_en, out_ready,
        output in_ready, out_valid, pos_clause_1, neg_clause_1,
               pos_clause_2, neg_clause_2, pred_class
    );
endinterface

// File: rtl/tm_clause_update.sv
// Combinational next-state for the TA states of one clause.
// Ports: state (current TA states), lit (literal vector), clause (clause
// output with empty clause = 1), fb (feedback type), inc_ev / dec_ev
// (per-literal "(s-1)/s" and "1/s" events), next_state (saturating result).
module tm_clause_update
    import tm_pkg::*;
#(
    parameter int NL = TM_NL,
    parameter int SW = TM_SW
) (
    input  logic [NL-1:0][SW-1:0] state,
    input  logic [NL-1:0]         lit,
    input  logic                  clause,
    input  fb_t                   fb,
    input  logic [NL-1:0]         inc_ev,
    input  logic [NL-1:0]         dec_ev,
    output logic [NL-1:0][SW-1:0] next_state
);
    localparam logic [SW-1:0] S_MAX = '1;

    for (genvar k = 0; k < NL; k++) begin : g_lit
        logic up, dn;
        // Type I reinforces true literals of a firing clause; Type II pushes
        // false, excluded literals toward inclusion to block the clause.
        assign up = clause && ((fb == FB_TYPE1 && lit[k] && inc_ev[k]) ||
                               (fb == FB_TYPE2 && !lit[k] && !state[k][SW-1]));
        // Type I forgets everything else at rate 1/s.
        assign dn = (fb == FB_TYPE1) && dec_ev[k] && !(clause && lit[k]);
        assign next_state[k] = (up && state[k] != S_MAX) ? state[k] + SW'(1) :
                               (dn && state[k] != '0)    ? state[k] - SW'(1) :
                                                           state[k];
    end
endmodule

// File: rtl/tm_train_engine.sv
// 2-class Tsetlin Machine front end: holds all TA states, evaluates clauses
// for a presented sample, reports per-class clause vectors and the predicted
// class, and optionally applies Type I/II feedback one clause per cycle.
// Ports: clk, rst (sync, active high), bus (slave side of
// tm_train_engine_if carrying the sample and result handshakes).
module tm_train_engine
    import tm_pkg::*;
#(
    parameter int          N_FEAT   = TM_N_FEAT,
    parameter int          N_CLAUSE = TM_N_CLAUSE,
    parameter int          SW       = TM_SW,
    parameter int          T        = 2,
    parameter int          S_INV    = 32,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    tm_train_engine_if.slave  bus
);
    localparam int            NL     = 2 * N_FEAT;
    localparam int            NJ     = 2 * N_CLAUSE;
    localparam int            JW     = (NJ > 1) ? $clog2(NJ) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(NJ - 1);
    localparam logic [SW-1:0] TA_RST = SW'(ta_rst_val(SW));

    state_t                        st;
    logic [1:0][NJ-1:0][NL-1:0][SW-1:0] ta;
    logic [15:0]                   lfsr;
    logic [N_FEAT-1:0]             x_q;
    logic                          label_q, train_q, rand_en_q;
    logic                          upd_c;
    logic [JW-1:0]                 upd_j;
    logic                          in_ready_q, out_valid_q;
    logic [1:0][NJ-1:0]            cl_q;    // reported clauses, [j<N_CLAUSE] positive
    logic [1:0]                    class_q;

    logic [NL-1:0] lit;
    assign lit = {~x_q, x_q};

    function automatic logic [NL-1:0] incl(input logic [NL-1:0][SW-1:0] s);
        logic [NL-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) r[k] = s[k][SW-1];
        return r;
    endfunction

    function automatic int vote(input logic [NJ-1:0] cv);
        return $countones(cv[N_CLAUSE-1:0]) - $countones(cv[NJ-1:N_CLAUSE]);
    endfunction

    // Reported clause outputs: an empty clause reads as 0.
    logic [1:0][NJ-1:0] cl_eval;
    logic [1:0]         class_n;
    always_comb begin
        cl_eval = '0;
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < NJ; j++)
                cl_eval[c][j] = (|incl(ta[c][j])) && (&(lit | ~incl(ta[c][j])));
        class_n = (vote(cl_eval[0]) >= vote(cl_eval[1])) ? 2'b00 : 2'b01;
    end

    // Feedback selection for the clause visited this UPD cycle. Votes come
    // from the registered (pre-update) clause outputs.
    logic [NL-1:0][SW-1:0] cur_s, nxt_s;
    logic                  fb_clause;
    fb_t                   fb;
    always_comb begin
        int   v;
        int   thr;
        int   rnd;
        logic own;
        logic sel;
        own = (upd_c == label_q);
        v   = vote(cl_q[upd_c]);
        if (v > T)       v = T;
        else if (v < -T) v = -T;
        thr = own ? (T - v) : (T + v);
        rnd = (int'(lfsr[15:8]) * 2 * T) >>> 8;
        sel = !rand_en_q || (rnd < thr);
        cur_s     = ta[upd_c][upd_j];
        // for learning, an empty clause counts as firing
        fb_clause = &(lit | ~incl(cur_s));
        if (!sel)                                  fb = FB_NONE;
        else if ((upd_j < JW'(N_CLAUSE)) == own)   fb = FB_TYPE1;
        else                                       fb = FB_TYPE2;
    end

    // Per-literal random events from the LFSR rotated by 4k.
    logic [NL-1:0] inc_ev, dec_ev;
    for (genvar k = 0; k < NL; k++) begin : g_ev
        localparam int R = (4 * k) % 16;
        logic [15:0] rot;
        logic        hit;
        assign rot       = (lfsr << R) | (lfsr >> ((16 - R) % 16));
        assign hit       = int'(rot[7:0]) < S_INV;
        assign dec_ev[k] = rand_en_q && hit;
        assign inc_ev[k] = !rand_en_q || !hit;
    end

    tm_clause_update #(.NL(NL), .SW(SW)) u_upd (
        .state      (cur_s),
        .lit        (lit),
        .clause     (fb_clause),
        .fb         (fb),
        .inc_ev     (inc_ev),
        .dec_ev     (dec_ev),
        .next_state (nxt_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= IDLE;
            ta          <= {(2 * NJ * NL){TA_RST}};
            lfsr        <= SEED;
            x_q         <= '0;
            label_q     <= 1'b0;
            train_q     <= 1'b0;
            rand_en_q   <= 1'b0;
            upd_c       <= 1'b0;
            upd_j       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cl_q        <= '0;
            class_q     <= 2'b00;
        end else begin
            case (st)
                IDLE: if (bus.in_valid) begin
                    x_q        <= bus.x;
                    label_q    <= bus.label;
                    train_q    <= bus.train;
                    rand_en_q  <= bus.rand_en;
                    in_ready_q <= 1'b0;
                    st         <= EVAL;
                end
                EVAL: begin
                    cl_q    <= cl_eval;
                    class_q <= class_n;
                    upd_c   <= 1'b0;
                    upd_j   <= '0;
                    if (train_q) st <= UPD;
                    else begin
                        st          <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                UPD: begin
                    ta[upd_c][upd_j] <= nxt_s;
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    if (upd_j == J_LAST) begin
                        upd_j <= '0;
                        upd_c <= ~upd_c;
                        if (upd_c) begin
                            st          <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end else begin
                        upd_j <= upd_j + JW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    st          <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.pos_clause_1 = cl_q[0][N_CLAUSE-1:0];
    assign bus.neg_clause_1 = cl_q[0][NJ-1:N_CLAUSE];
    assign bus.pos_clause_2 = cl_q[1][N_CLAUSE-1:0];
    assign bus.neg_clause_2 = cl_q[1][NJ-1:N_CLAUSE];
    assign bus.pred_class   = class_q;
endmodule

// File: tb/tb_tm_train_engine.sv
// Self-checking bench for tm_train_engine: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level behavioural model of the Tsetlin Machine.
module tb_tm_train_engine;
    localparam int          NF   = 2;
    localparam int          NC   = 2;
    localparam int          SWB  = 4;
    localparam int          TT   = 2;
    localparam int          SINV = 32;
    localparam logic [15:0] SEEDV = 16'hACE1;
    localparam int NLB  = 2 * NF;
    localparam int NJB  = 2 * NC;
    localparam int SMAX = (1 << SWB) - 1;
    localparam int SRST = (1 << (SWB - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rand_or = 1'b0;

    tm_train_engine_if #(.N_FEAT(NF), .N_CLAUSE(NC)) bus();

    tm_train_engine #(.N_FEAT(NF), .N_CLAUSE(NC), .SW(SWB), .T(TT),
                      .S_INV(SINV), .SEED(SEEDV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- behavioural model ----------------
    int   m_ta[2][NJB][NLB];
    int   m_lfsr;
    logic exp_ready, exp_valid;
    int   m_cnt;
    int   e_pos[2], e_neg[2], e_cls;

    function automatic int lit_of(input int xv, input int k);
        return (k < NF) ? ((xv >> k) & 1) : (((xv >> (k - NF)) & 1) ^ 1);
    endfunction

    function automatic int clause_val(input int c, input int j, input int xv, input int empty_val);
        int n, ok;
        n = 0; ok = 1;
        for (int k = 0; k < NLB; k++)
            if (m_ta[c][j][k] > SRST) begin
                n++;
                if (lit_of(xv, k) == 0) ok = 0;
            end
        return (n == 0) ? empty_val : ok;
    endfunction

    function automatic int rot_byte(input int lf, input int k);
        int r;
        r = (4 * k) % 16;
        return ((lf << r) | (lf >> (16 - r))) & 255;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < NJB; j++)
                for (int k = 0; k < NLB; k++) m_ta[c][j][k] = SRST;
        m_lfsr = SEEDV; exp_ready = 1; exp_valid = 0; m_cnt = 0;
        e_pos[0] = 0; e_pos[1] = 0; e_neg[0] = 0; e_neg[1] = 0; e_cls = 0;
    endtask

    task automatic model_infer(input int xv);
        int v[2];
        for (int c = 0; c < 2; c++) begin
            e_pos[c] = 0; e_neg[c] = 0; v[c] = 0;
            for (int j = 0; j < NC; j++) begin
                e_pos[c] |= clause_val(c, j, xv, 0) << j;
                e_neg[c] |= clause_val(c, j + NC, xv, 0) << j;
                v[c] += clause_val(c, j, xv, 0) - clause_val(c, j + NC, xv, 0);
            end
        end
        e_cls = (v[0] >= v[1]) ? 0 : 1;
    endtask

    task automatic model_train(input int xv, input int lab, input int ren);
        int v[2];
        for (int c = 0; c < 2; c++) begin
            v[c] = 0;
            for (int j = 0; j < NC; j++)
                v[c] += clause_val(c, j, xv, 0) - clause_val(c, j + NC, xv, 0);
            if (v[c] > TT) v[c] = TT;
            if (v[c] < -TT) v[c] = -TT;
        end
        for (int c = 0; c < 2; c++)
            for (int j = 0; j < NJB; j++) begin
                int thr, rnd, cl, fbk;
                bit sel, type1;
                thr   = (c == lab) ? TT - v[c] : TT + v[c];
                rnd   = ((m_lfsr >> 8) * 2 * TT) / 256;
                sel   = (ren == 0) || (rnd < thr);
                type1 = ((j < NC) == (c == lab));
                cl    = clause_val(c, j, xv, 1);
                if (sel)
                    for (int k = 0; k < NLB; k++) begin
                        bit lo, hi;
                        int l, d;
                        lo = (ren != 0) && (rot_byte(m_lfsr, k) < SINV);
                        hi = (ren == 0) || !(rot_byte(m_lfsr, k) < SINV);
                        l  = lit_of(xv, k);
                        d  = 0;
                        if (type1) begin
                            if (cl == 1 && l == 1) d = hi ? 1 : 0;
                            else                   d = lo ? -1 : 0;
                        end else if (cl == 1 && l == 0 && m_ta[c][j][k] <= SRST) d = 1;
                        fbk = m_ta[c][j][k] + d;
                        m_ta[c][j][k] = (fbk < 0) ? 0 : (fbk > SMAX) ? SMAX : fbk;
                    end
                m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^
                          (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
            end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) model_reset();
        else if (exp_ready && bus.in_valid) begin
            model_infer(int'(bus.x));
            if (bus.train) model_train(int'(bus.x), int'(bus.label), int'(bus.rand_en));
            exp_ready = 0;
            m_cnt = bus.train ? 1 + 4 * NC : 1;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) exp_valid = 1;
        end else if (exp_valid && bus.out_ready) begin
            exp_valid = 0; exp_ready = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) if (!rst) begin
        chk("in_ready", int'(bus.in_ready), int'(exp_ready));
        chk("out_valid", int'(bus.out_valid), int'(exp_valid));
        if (exp_valid) begin
            chk("pos_clause_1", int'(bus.pos_clause_1), e_pos[0]);
            chk("neg_clause_1", int'(bus.neg_clause_1), e_neg[0]);
            chk("pos_clause_2", int'(bus.pos_clause_2), e_pos[1]);
            chk("neg_clause_2", int'(bus.neg_clause_2), e_neg[1]);
            chk("class", int'(bus.pred_class), e_cls);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_or) bus.out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- stimulus helpers ----------------
    int cap_p1, cap_n1, cap_p2, cap_n2, cap_cls;

    task automatic capture();
        cap_p1 = int'(bus.pos_clause_1); cap_n1 = int'(bus.neg_clause_1);
        cap_p2 = int'(bus.pos_clause_2); cap_n2 = int'(bus.neg_clause_2);
        cap_cls = int'(bus.pred_class);
    endtask

    task automatic offer(input int xv, input int lab, input int tr, input int ren, output int acc_cyc);
        int n;
        logic acc;
        bus.x = 2'(xv); bus.label = 1'(lab); bus.train = 1'(tr); bus.rand_en = 1'(ren);
        bus.in_valid = 1'b1;
        n = 0; acc = 1'b0; acc_cyc = -1;
        while (!acc && n < 100) begin
            @(negedge clk); acc = bus.in_ready; acc_cyc = cyc;
            @(posedge clk); #2; n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int vc);
        int n;
        n = 0; vc = -1;
        while (vc < 0 && n < 100) begin
            if (bus.out_valid) begin vc = cyc; capture(); end
            else begin @(posedge clk); #2; n++; end
        end
        if (vc < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(posedge clk); #2; n++; end
        if (!bus.in_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input int xv, input int lab, input int tr, input int ren, output int lat);
        int ac, vc;
        offer(xv, lab, tr, ren, ac);
        wait_valid(vc);
        lat = (vc < 0 || ac < 0) ? -1 : vc - ac;
        wait_idle();
    endtask

    task automatic chk_cap(input string tag, input int p1, input int n1, input int p2, input int n2, input int cl);
        chk({tag, "_pos1"}, cap_p1, p1);
        chk({tag, "_neg1"}, cap_n1, n1);
        chk({tag, "_pos2"}, cap_p2, p2);
        chk({tag, "_neg2"}, cap_n2, n2);
        chk({tag, "_class"}, cap_cls, cl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ac, vc;
        bus.in_valid = 0; bus.x = '0; bus.label = 0; bus.train = 0; bus.rand_en = 0;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #2; rst = 0;
        // reset state
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        capture(); chk_cap("rst", 0, 0, 0, 0, 0);

        // fresh inference: everything excluded
        send(1, 0, 0, 0, lat);
        chk("lat_infer", lat, 2);
        chk_cap("s1", 0, 0, 0, 0, 0);

        // one deterministic training pass, then infer both patterns
        send(1, 0, 1, 0, lat);
        chk("lat_train", lat, 2 + 4 * NC);
        send(1, 0, 0, 0, lat);
        chk_cap("s2", 3, 0, 0, 3, 0);
        chk("s2_model_pos1", e_pos[0], 3);
        chk("s2_model_neg2", e_neg[1], 3);
        send(2, 0, 0, 0, lat);
        chk_cap("s3", 0, 3, 3, 0, 1);
        chk("s3_model_class", e_cls, 1);

        // saturation
        for (int i = 0; i < 10; i++) send(1, 0, 1, 0, lat);
        chk("sat_model", m_ta[0][0][0], 15);
        chk("sat_dut", int'(dut.ta[0][0][0]), 15);
        chk("sat_dut_excl", int'(dut.ta[0][0][1]), 7);
        send(1, 0, 0, 0, lat);
        chk_cap("s4", 3, 0, 0, 3, 0);

        // backpressure: result held, second sample waits
        bus.out_ready = 0;
        offer(1, 0, 0, 0, ac);
        bus.x = 2'b10; bus.label = 0; bus.train = 0; bus.rand_en = 0; bus.in_valid = 1;
        wait_valid(vc);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            chk("hold_in_ready", int'(bus.in_ready), 0);
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_pos1", int'(bus.pos_clause_1), cap_p1);
            chk("hold_neg2", int'(bus.neg_clause_2), cap_n2);
        end
        bus.out_ready = 1;
        @(posedge clk); #2;
        chk("hold_release_ready", int'(bus.in_ready), 1);
        @(posedge clk); #2;
        chk("hold_second_accepted", int'(bus.in_ready), 0);
        bus.in_valid = 0;
        wait_valid(vc);
        chk_cap("s5", 0, 3, 3, 0, 1);
        wait_idle();

        // reset during the 3rd update cycle
        offer(1, 0, 1, 0, ac);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1;
        @(posedge clk); #2;
        chk("abort_in_ready", int'(bus.in_ready), 1);
        chk("abort_out_valid", int'(bus.out_valid), 0);
        rst = 0;
        send(1, 0, 0, 0, lat);
        chk_cap("s6", 0, 0, 0, 0, 0);

        // randomized traffic against the model
        rand_or = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0, lat);
        end
        rand_or = 0;
        #2;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
